// File: rtl/upsampling_module.sv
// Nearest-neighbour 2x image upsampler.
// One input row is captured into a small register buffer, then replayed
// twice (EMIT_A, EMIT_B) with every pixel doubled horizontally, so each
// input pixel covers a 2x2 block of the output image.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FILL   | accepting input pixels into row_buf, Input_Ready high
// EMIT_A | first copy of the buffered row, one output pixel per cycle
// EMIT_B | second copy of the same row, then back to FILL or to DONE
// DONE   | one-cycle Output_Finish pulse, then back to FILL
module upsampling_module #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 4
) (
    input  logic                  Clock,
    input  logic                  Input_Reset,
    input  logic [DATA_WIDTH-1:0] Input_Pixel,
    input  logic                  Input_Valid,
    input  logic                  Input_Finish,
    output logic                  Input_Ready,
    output logic [DATA_WIDTH-1:0] Output_Pixel,
    output logic                  Output_Valid,
    output logic                  Output_Finish,
    output logic [15:0]           Watch
);

    // Column counters are at least 4 bits wide so the debug word can always
    // show the low nibble of each.
    localparam int COL_W = ($clog2(2 * IN_WIDTH) > 4) ? $clog2(2 * IN_WIDTH) : 4;

    localparam logic [COL_W-1:0] IN_LAST  = COL_W'(IN_WIDTH - 1);
    localparam logic [COL_W-1:0] OUT_LAST = COL_W'(2 * IN_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        EMIT_A = 2'd1,
        EMIT_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state;
    logic [COL_W-1:0]        in_col;
    logic [COL_W-1:0]        out_col;
    logic [DATA_WIDTH-1:0]   row_buf [IN_WIDTH];

    // finish_armed: an Input_Finish level may end only one image; it must be
    // seen low again before another Output_Finish can be produced.
    logic                    finish_armed;
    // last_row: the row being emitted was closed by Input_Finish (partial
    // row, zero-filled), so DONE follows regardless of the finish level.
    logic                    last_row;

    logic                    xfer;
    logic                    row_full;
    logic                    finish_req;
    logic [COL_W-1:0]        in_col_next;
    logic [COL_W-1:0]        next_idx;
    logic [DATA_WIDTH-1:0]   next_pix;
    logic [DATA_WIDTH-1:0]   first_pix;

    // Ready is held low while reset is asserted even though state is FILL.
    assign Input_Ready = (state == FILL) && !Input_Reset;

    assign Watch = {state, 6'b0, out_col[3:0], in_col[3:0]};

    // Transfer qualification, column look-ahead and buffer read muxes.
    always_comb begin
        xfer        = Input_Valid && (state == FILL);
        in_col_next = xfer ? (in_col + COL_ONE) : in_col;
        row_full    = xfer && (in_col == IN_LAST);
        finish_req  = Input_Finish && finish_armed;

        // Pixel for the next output column: each buffer entry is used twice.
        next_idx = (out_col + COL_ONE) >> 1;
        next_pix = '0;
        for (int j = 0; j < IN_WIDTH; j++) begin
            if (COL_W'(j) == next_idx) begin
                next_pix = row_buf[j];
            end
        end

        // Column 0 of a new row: bypass the pixel being written this cycle
        // when it lands in buffer slot 0 (single-pixel partial row, or
        // IN_WIDTH of 1).
        first_pix = (xfer && (in_col == '0)) ? Input_Pixel : row_buf[0];
    end

    // Sequencer with registered pixel, valid and finish outputs.
    always_ff @(posedge Clock or posedge Input_Reset) begin
        if (Input_Reset) begin
            state         <= FILL;
            in_col        <= '0;
            out_col       <= '0;
            Output_Pixel  <= '0;
            Output_Valid  <= 1'b0;
            Output_Finish <= 1'b0;
            finish_armed  <= 1'b1;
            last_row      <= 1'b0;
            for (int j = 0; j < IN_WIDTH; j++) begin
                row_buf[j] <= '0;
            end
        end else begin
            if (!Input_Finish) begin
                finish_armed <= 1'b1;
            end

            case (state)
                FILL: begin
                    Output_Valid  <= 1'b0;
                    Output_Finish <= 1'b0;

                    for (int j = 0; j < IN_WIDTH; j++) begin
                        if (xfer && (COL_W'(j) == in_col)) begin
                            row_buf[j] <= Input_Pixel;
                        end
                    end

                    // The accepted pixel (if any) is accounted for first;
                    // the finish decisions below look at in_col_next.
                    if (row_full) begin
                        in_col       <= '0;
                        out_col      <= '0;
                        state        <= EMIT_A;
                        Output_Pixel <= first_pix;
                        Output_Valid <= 1'b1;
                        last_row     <= 1'b0;
                    end else if (finish_req && (in_col_next == '0)) begin
                        in_col        <= '0;
                        state         <= DONE;
                        Output_Finish <= 1'b1;
                        finish_armed  <= 1'b0;
                    end else if (finish_req) begin
                        // Partial last row: pad the unfilled tail with zeros.
                        for (int j = 0; j < IN_WIDTH; j++) begin
                            if (COL_W'(j) >= in_col_next) begin
                                row_buf[j] <= '0;
                            end
                        end
                        in_col       <= '0;
                        out_col      <= '0;
                        state        <= EMIT_A;
                        Output_Pixel <= first_pix;
                        Output_Valid <= 1'b1;
                        last_row     <= 1'b1;
                    end else begin
                        in_col <= in_col_next;
                    end
                end

                EMIT_A, EMIT_B: begin
                    Output_Finish <= 1'b0;
                    if (out_col == OUT_LAST) begin
                        out_col <= '0;
                        if (state == EMIT_A) begin
                            state        <= EMIT_B;
                            Output_Pixel <= row_buf[0];
                            Output_Valid <= 1'b1;
                        end else if (last_row || finish_req) begin
                            state         <= DONE;
                            Output_Valid  <= 1'b0;
                            Output_Finish <= 1'b1;
                            finish_armed  <= 1'b0;
                            last_row      <= 1'b0;
                        end else begin
                            state        <= FILL;
                            Output_Valid <= 1'b0;
                        end
                    end else begin
                        out_col      <= out_col + COL_ONE;
                        Output_Pixel <= next_pix;
                        Output_Valid <= 1'b1;
                    end
                end

                DONE: begin
                    state         <= FILL;
                    Output_Valid  <= 1'b0;
                    Output_Finish <= 1'b0;
                end

                default: begin
                    state         <= FILL;
                    Output_Valid  <= 1'b0;
                    Output_Finish <= 1'b0;
                end
            endcase
        end
    end

endmodule
